// File: rtl/pe_result_collector_if.sv
// AXI-Stream result bus leaving the collector: data, lane index, row-complete flag, valid/ready.
interface pe_result_collector_if #(
    parameter int DATA_BITS = 16,
    parameter int USER_BITS = 3
);
    logic [DATA_BITS-1:0] tdata;
    logic [USER_BITS-1:0] tuser;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tuser, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/pe_result_collector.sv
// Purpose: latch each PE result on its finish rise and serialise lanes, lowest index first, into an AXI-S FIFO.
// Latency: finish rise in cycle n -> captured end of n, pushed end of n+1, tvalid in n+2.
// Backpressure: tready low fills the FIFO; when full, lanes stay pending and a repeat rise flags o_overrun.
module pe_result_collector #(
    parameter int N_LANES    = 8,
    parameter int DATA_BITS  = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int LANE_W    = $clog2(N_LANES),
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [N_LANES-1:0]             i_finish,
    input  logic [N_LANES*DATA_BITS-1:0]   i_c,
    input  logic                           i_clear,
    pe_result_collector_if.master          axis,
    output logic [LVL_W-1:0]               o_level,
    output logic                           o_overrun
);

    typedef struct packed {
        logic                 last;
        logic [LANE_W-1:0]    lane;
        logic [DATA_BITS-1:0] dat;
    } entry_t;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    logic [N_LANES-1:0]   finish_d;
    logic [N_LANES-1:0]   rise;
    logic [N_LANES-1:0]   pend;
    logic [DATA_BITS-1:0] cap [N_LANES];

    entry_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;

    logic                 sel_vld;
    logic [LANE_W-1:0]    sel_idx;
    logic                 push;
    logic                 pop;
    logic [N_LANES-1:0]   push_oh;
    entry_t               push_ent;
    entry_t               head;

    // o_finish is a level held until the next matrix, so only the rising edge is a new result
    assign rise = i_finish & ~finish_d;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (pend[k]) begin
                sel_vld = 1'b1;
                sel_idx = LANE_W'(k);
            end
        end
    end

    // Full blocks the push on the pre-pop level, even if the head leaves this cycle
    assign push    = sel_vld && (level < DEPTH_L) && !i_clear;
    assign pop     = axis.tvalid && axis.tready && !i_clear;
    assign push_oh = push ? (N_LANES'(1) << sel_idx) : '0;

    always_comb begin
        push_ent      = '0;
        push_ent.last = (sel_idx == LANE_W'(N_LANES - 1));
        push_ent.lane = sel_idx;
        push_ent.dat  = cap[sel_idx];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            finish_d  <= '0;
            pend      <= '0;
            o_overrun <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                cap[k] <= '0;
            end
        end else begin
            finish_d <= i_finish;
            for (int k = 0; k < N_LANES; k++) begin
                if (rise[k]) begin
                    cap[k] <= i_c[k*DATA_BITS +: DATA_BITS];
                end
            end
            if (i_clear) begin
                pend      <= '0;
                o_overrun <= 1'b0;
            end else begin
                // A rise on the lane being pushed re-arms it; the old value already left
                pend <= (pend & ~push_oh) | rise;
                if (|(rise & pend & ~push_oh)) begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign axis.tvalid = (level != '0);
    assign axis.tdata  = axis.tvalid ? head.dat  : '0;
    assign axis.tuser  = axis.tvalid ? head.lane : '0;
    assign axis.tlast  = axis.tvalid ? head.last : 1'b0;
    assign o_level     = level;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench: a 16-deep and a 4-deep collector share the lane inputs, each with its own consumer.
module tb_pe_result_collector;

    logic         clk;
    logic         rst_n;
    logic [7:0]   finish;
    logic [127:0] c;
    logic         clear;
    logic [4:0]   level16;
    logic [2:0]   level4;
    logic         ovr16;
    logic         ovr4;

    int errors = 0;
    int checks = 0;

    logic [19:0] q16[$];
    logic [19:0] q4[$];
    logic [19:0] exp_q[$];

    pe_result_collector_if #(.DATA_BITS(16), .USER_BITS(3)) bus16 ();
    pe_result_collector_if #(.DATA_BITS(16), .USER_BITS(3)) bus4 ();

    pe_result_collector #(.N_LANES(8), .DATA_BITS(16), .FIFO_DEPTH(16)) u_dut16 (
        .i_clock(clk), .i_reset(rst_n), .i_finish(finish), .i_c(c), .i_clear(clear),
        .axis(bus16), .o_level(level16), .o_overrun(ovr16)
    );

    pe_result_collector #(.N_LANES(8), .DATA_BITS(16), .FIFO_DEPTH(4)) u_dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_finish(finish), .i_c(c), .i_clear(clear),
        .axis(bus4), .o_level(level4), .o_overrun(ovr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus16.tvalid && bus16.tready) q16.push_back({bus16.tlast, bus16.tuser, bus16.tdata});
        if (bus4.tvalid && bus4.tready)   q4.push_back({bus4.tlast, bus4.tuser, bus4.tdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] fin;
        logic       rdy;
        logic       exp_vld;
        logic [4:0] exp_lvl;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input logic [19:0] got[$], input logic [19:0] want[$]);
        chk({nm, " beat count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            chk($sformatf("%s beat %0d", nm, i), got[i], want[i]);
        end
    endtask

    function automatic logic [19:0] beat(input int lane, input logic [15:0] d);
        return {lane == 7, 3'(lane), d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input int k, input logic [15:0] v);
        c[k*16 +: 16] = v;
    endtask

    task automatic idle_clear();
        finish = 8'h00;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        q16.delete();
        q4.delete();
    endtask

    initial begin
        // Simultaneous-rise table for the 16-deep instance: fill with ready low, then drain
        tbl[0]  = '{8'hFF, 1'b0, 1'b0, 5'd0};  tbl[1]  = '{8'hFF, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{8'hFF, 1'b0, 1'b1, 5'd1};  tbl[3]  = '{8'hFF, 1'b0, 1'b1, 5'd2};
        tbl[4]  = '{8'hFF, 1'b0, 1'b1, 5'd3};  tbl[5]  = '{8'hFF, 1'b0, 1'b1, 5'd4};
        tbl[6]  = '{8'hFF, 1'b0, 1'b1, 5'd5};  tbl[7]  = '{8'hFF, 1'b0, 1'b1, 5'd6};
        tbl[8]  = '{8'hFF, 1'b0, 1'b1, 5'd7};  tbl[9]  = '{8'hFF, 1'b0, 1'b1, 5'd8};
        tbl[10] = '{8'hFF, 1'b0, 1'b1, 5'd8};  tbl[11] = '{8'hFF, 1'b1, 1'b1, 5'd8};
        tbl[12] = '{8'hFF, 1'b1, 1'b1, 5'd7};  tbl[13] = '{8'hFF, 1'b1, 1'b1, 5'd6};
        tbl[14] = '{8'hFF, 1'b1, 1'b1, 5'd5};  tbl[15] = '{8'hFF, 1'b1, 1'b1, 5'd4};
        tbl[16] = '{8'hFF, 1'b1, 1'b1, 5'd3};  tbl[17] = '{8'hFF, 1'b1, 1'b1, 5'd2};
        tbl[18] = '{8'hFF, 1'b1, 1'b1, 5'd1};  tbl[19] = '{8'hFF, 1'b1, 1'b0, 5'd0};

        rst_n = 1'b0;
        finish = 8'hFF;
        clear = 1'b0;
        c = '0;
        bus16.tready = 1'b0;
        bus4.tready = 1'b0;

        // Reset held with every lane finished
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tvalid16", bus16.tvalid, 0);
        chk("reset level16", level16, 0);
        chk("reset overrun16", ovr16, 0);
        chk("reset tdata16", bus16.tdata, 0);
        chk("reset tvalid4", bus4.tvalid, 0);
        step();
        finish = 8'h00;
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("idle tvalid16", bus16.tvalid, 0);
        chk("idle level16", level16, 0);
        step();

        // Skewed row: one lane rises per cycle
        bus16.tready = 1'b1;
        bus4.tready = 1'b1;
        for (int k = 0; k < 8; k++) set_c(k, 16'(256 * k + 1));
        for (int k = 0; k < 8; k++) begin
            finish[k] = 1'b1;
            @(negedge clk);
            if (k == 1) chk("skew no tvalid at +1", bus16.tvalid, 0);
            if (k == 2) chk("skew first tvalid at +2", bus16.tvalid, 1);
            step();
        end
        repeat (8) step();
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(beat(k, 16'(256 * k + 1)));
        chk_q("skew dut16", q16, exp_q);
        chk_q("skew dut4", q4, exp_q);
        chk("skew overrun16", ovr16, 0);

        // All lanes rise together
        idle_clear();
        for (int k = 0; k < 8; k++) set_c(k, 16'hA000 + 16'(k));
        bus4.tready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            finish = tbl[r].fin;
            bus16.tready = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("simul row %0d tvalid", r), bus16.tvalid, tbl[r].exp_vld);
            chk($sformatf("simul row %0d level", r), level16, tbl[r].exp_lvl);
            step();
        end
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(beat(k, 16'hA000 + 16'(k)));
        chk_q("simul dut16", q16, exp_q);

        // Depth-4 backpressure: four queued, four held pending
        idle_clear();
        bus16.tready = 1'b1;
        bus4.tready = 1'b0;
        for (int k = 0; k < 8; k++) set_c(k, 16'hB000 + 16'(k));
        finish = 8'hFF;
        repeat (10) step();
        @(negedge clk);
        chk("full level4", level4, 4);
        chk("full head tuser", bus4.tuser, 0);
        chk("full head tdata", bus4.tdata, 16'hB000);
        step();
        bus4.tready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(beat(k, 16'hB000 + 16'(k)));
        chk_q("full drain", q4, exp_q);
        chk("full overrun4", ovr4, 0);
        chk("full level4 after drain", level4, 0);
        step();

        // Overrun: lane 3 finishes twice while stuck behind a full FIFO
        idle_clear();
        bus4.tready = 1'b0;
        for (int k = 4; k < 8; k++) set_c(k, 16'h4000 + 16'(k));
        finish = 8'hF0;
        repeat (6) step();
        set_c(3, 16'h1111);
        finish = 8'hF8;
        repeat (2) step();
        finish = 8'hF0;
        step();
        set_c(3, 16'h2222);
        finish = 8'hF8;
        repeat (2) step();
        @(negedge clk);
        chk("ovr flag set", ovr4, 1);
        chk("ovr level4", level4, 4);
        step();
        bus4.tready = 1'b1;
        repeat (10) step();
        exp_q.delete();
        for (int k = 4; k < 8; k++) exp_q.push_back(beat(k, 16'h4000 + 16'(k)));
        exp_q.push_back(beat(3, 16'h2222));
        chk_q("ovr drain", q4, exp_q);
        bus4.tready = 1'b0;
        set_c(0, 16'h0ABC);
        finish = 8'hF9;
        repeat (3) step();
        @(negedge clk);
        chk("ovr refill level4", level4, 1);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        chk("clear overrun4", ovr4, 0);
        chk("clear level4", level4, 0);
        chk("clear tvalid4", bus4.tvalid, 0);
        step();

        // Collision: lane 0 rises again in the cycle its first value is pushed
        idle_clear();
        bus4.tready = 1'b0;
        for (int k = 4; k < 8; k++) set_c(k, 16'h6000 + 16'(k));
        finish = 8'hF0;
        repeat (6) step();
        set_c(0, 16'hAAAA);
        finish = 8'hF1;
        repeat (2) step();
        finish = 8'hF0;
        step();
        bus4.tready = 1'b1;
        step();
        set_c(0, 16'hBBBB);
        finish = 8'hF1;
        repeat (10) step();
        @(negedge clk);
        exp_q.delete();
        for (int k = 4; k < 8; k++) exp_q.push_back(beat(k, 16'h6000 + 16'(k)));
        exp_q.push_back(beat(0, 16'hAAAA));
        exp_q.push_back(beat(0, 16'hBBBB));
        chk_q("collide drain", q4, exp_q);
        chk("collide overrun4", ovr4, 0);
        chk("collide overrun16", ovr16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
